// File: rtl/iob_spi_fl_burst_reader.sv
// Burst-read sequencer for the SPI flash controller: issues one single-word read per
// flash word and streams the returned words out through a small fall-through FIFO.
module iob_spi_fl_burst_reader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       cmd,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              fl_valid,
  output logic [31:0]       fl_address,
  output logic [31:0]       fl_command,
  input  logic              fl_ready,
  input  logic [DATA_W-1:0] fl_dataout
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [ADDR_W-1:0]  ADDR_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [31:0]         cmd_q, cmd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fl_valid_q, fl_valid_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic push, pop, fifo_full;

  assign fifo_full = (count_q == DEPTH_CNT);
  assign push      = (state_q == S_WAIT) && fl_ready;
  assign pop       = m_valid && m_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fl_valid_d = 1'b0;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d   = start_addr;
            remain_d = len;
            cmd_d    = cmd;
            busy_d   = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Only issue when the returning word is guaranteed a FIFO slot.
      S_ISSUE: begin
        if (!fifo_full && fl_ready) begin
          fl_valid_d = 1'b1;
          state_d    = S_ARM;
        end
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (fl_ready) begin
          addr_d   = addr_q + ADDR_STEP;
          remain_d = remain_q - 1'b1;
          state_d  = (remain_q == LEN_W'(1)) ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fl_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fl_valid_q <= fl_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; emptiness is tracked by count_q, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= fl_dataout;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign m_valid    = (count_q != '0);
  assign m_data     = mem[rd_ptr_q];
  // A reset arriving mid-burst withdraws the request immediately rather than one edge later.
  assign fl_valid   = fl_valid_q && !rst;
  assign fl_address = 32'(addr_q);
  assign fl_command = cmd_q;

endmodule

// File: tb/tb_iob_spi_fl_burst_reader.sv
// Self-checking bench for iob_spi_fl_burst_reader: a flash-controller model with configurable
// ready lag, a queue-based expectation model, and one per-cycle compare process.
module tb_iob_spi_fl_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] start_addr;
  logic [7:0]  len;
  logic [31:0] cmd;
  logic        busy, done, m_valid, m_ready;
  logic [31:0] m_data;
  logic        fl_valid, fl_ready;
  logic [31:0] fl_address, fl_command, fl_dataout;

  iob_spi_fl_burst_reader #(
    .DATA_W(32), .ADDR_W(24), .LEN_W(8), .FIFO_AW(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len), .cmd(cmd),
    .busy(busy), .done(done), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fl_valid(fl_valid), .fl_address(fl_address), .fl_command(fl_command),
    .fl_ready(fl_ready), .fl_dataout(fl_dataout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int lag = 3;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_cmd = '0;
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  // Flash contents: each word is a fixed function of its byte address.
  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return {8'hA5, a[23:0]} ^ 32'h0055_AA00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flash controller: ready drops after seeing a request, returns data `lag` cycles later.
  initial begin
    logic [31:0] a;
    fl_ready   = 1'b1;
    fl_dataout = '0;
    forever begin
      @(negedge clk);
      if (fl_valid) begin
        a        = fl_address;
        fl_ready = 1'b0;
        repeat (lag) @(negedge clk);
        fl_dataout = flash_word(a);
        fl_ready   = 1'b1;
      end
    end
  end

  // Compare process: every request and every stream handshake is checked against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (fl_valid) begin
          issue_cnt++;
          seen_addr.push_back(fl_address);
          check("issue_expected", 32'(exp_addr.size() != 0), 32'd1);
          if (exp_addr.size() != 0) check("fl_address", fl_address, exp_addr.pop_front());
          check("fl_command", fl_command, exp_cmd);
        end
        if (prev_hold && m_valid) check("m_data_hold", m_data, prev_data);
        if (m_valid && m_ready) begin
          pop_cnt++;
          seen_data.push_back(m_data);
          check("word_expected", 32'(exp_data.size() != 0), 32'd1);
          if (exp_data.size() != 0) check("m_data", m_data, exp_data.pop_front());
        end
        if (done) done_cnt++;
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  task automatic pulse_start(input logic [23:0] a, input logic [7:0] n, input logic [31:0] c);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; len = n; cmd = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input logic [23:0] a, input logic [7:0] n, input logic [31:0] c);
    logic [23:0] cur;
    cur     = a;
    exp_cmd = c;
    seen_addr.delete();
    seen_data.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(32'(cur));
      exp_data.push_back(flash_word(32'(cur)));
      cur = cur + 24'd4;
    end
    pulse_start(a, n, c);
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, p0, d0;
    logic found;

    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; cmd = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_fl_valid", 32'(fl_valid), 32'd0);
    check("rst_fl_address", fl_address, 32'h0);
    check("rst_fl_command", fl_command, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: four words, consumer always ready, controller lag 3.
    lag = 3; m_ready = 1'b1;
    i0 = issue_cnt; p0 = pop_cnt; d0 = done_cnt;
    run_burst(24'h000100, 8'd4, 32'h0000_0B03);
    @(negedge clk);
    check("T1_busy", 32'(busy), 32'd1);
    wait_done("T1", 300);
    check("T1_issues", 32'(issue_cnt - i0), 32'd4);
    check("T1_pops", 32'(pop_cnt - p0), 32'd4);
    check("T1_dones", 32'(done_cnt - d0), 32'd1);
    check("T1_addr0", seen_addr[0], 32'h0000_0100);
    check("T1_addr1", seen_addr[1], 32'h0000_0104);
    check("T1_addr2", seen_addr[2], 32'h0000_0108);
    check("T1_addr3", seen_addr[3], 32'h0000_010C);
    check("T1_data0", seen_data[0], 32'hA555_AB00);
    check("T1_model_empty", 32'(exp_addr.size() + exp_data.size()), 32'd0);

    // T2: six words with the consumer stalled; FIFO depth 4 caps outstanding issues.
    lag = 1; m_ready = 1'b0;
    i0 = issue_cnt; p0 = pop_cnt; d0 = done_cnt;
    run_burst(24'h002000, 8'd6, 32'h0000_0B13);
    repeat (40) @(negedge clk);
    check("T2_issues_stalled", 32'(issue_cnt - i0), 32'd4);
    repeat (10) @(negedge clk);
    check("T2_issues_still", 32'(issue_cnt - i0), 32'd4);
    check("T2_m_valid", 32'(m_valid), 32'd1);
    check("T2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done("T2", 300);
    check("T2_issues", 32'(issue_cnt - i0), 32'd6);
    check("T2_pops", 32'(pop_cnt - p0), 32'd6);
    check("T2_dones", 32'(done_cnt - d0), 32'd1);
    check("T2_data4", seen_data[4], 32'hA555_8A10);
    check("T2_model_empty", 32'(exp_addr.size() + exp_data.size()), 32'd0);

    // T3: address wrap at the top of the 24-bit space.
    lag = 2;
    i0 = issue_cnt;
    run_burst(24'hFFFFF8, 8'd3, 32'h0000_0B23);
    wait_done("T3", 300);
    check("T3_issues", 32'(issue_cnt - i0), 32'd3);
    check("T3_addr0", seen_addr[0], 32'h00FF_FFF8);
    check("T3_addr1", seen_addr[1], 32'h00FF_FFFC);
    check("T3_addr2", seen_addr[2], 32'h0000_0000);
    check("T3_model_empty", 32'(exp_addr.size() + exp_data.size()), 32'd0);

    // T4: zero-length request.
    i0 = issue_cnt; d0 = done_cnt;
    pulse_start(24'h000700, 8'd0, 32'h0000_0B33);
    @(negedge clk);
    check("T4_done_pulse", 32'(done), 32'd1);
    check("T4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("T4_done_low", 32'(done), 32'd0);
    check("T4_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("T4_issues", 32'(issue_cnt - i0), 32'd0);
    check("T4_dones", 32'(done_cnt - d0), 32'd1);

    // T5: a start while busy is ignored.
    lag = 2;
    i0 = issue_cnt; d0 = done_cnt;
    run_burst(24'h000300, 8'd3, 32'h0000_0B43);
    repeat (3) @(posedge clk);
    pulse_start(24'h000500, 8'd2, 32'h0000_0B53);
    wait_done("T5", 300);
    repeat (5) @(negedge clk);
    check("T5_issues", 32'(issue_cnt - i0), 32'd3);
    check("T5_dones", 32'(done_cnt - d0), 32'd1);
    check("T5_addr0", seen_addr[0], 32'h0000_0300);
    check("T5_addr2", seen_addr[2], 32'h0000_0308);
    check("T5_seen_count", 32'(seen_addr.size()), 32'd3);

    // T6: reset mid-burst after two words are buffered, then a fresh burst.
    lag = 3; m_ready = 1'b0;
    i0 = issue_cnt; d0 = done_cnt;
    run_burst(24'h000400, 8'd4, 32'h0000_0B63);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); #1;
      found = (issue_cnt - i0 >= 3);
    end
    check("T6_third_issue_seen", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1 check("T6_fl_valid_drop", 32'(fl_valid), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk);
    @(negedge clk);
    check("T6_m_valid", 32'(m_valid), 32'd0);
    check("T6_busy", 32'(busy), 32'd0);
    check("T6_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("T6_no_done", 32'(done_cnt - d0), 32'd0);
    m_ready = 1'b1;
    i0 = issue_cnt; p0 = pop_cnt;
    run_burst(24'h000600, 8'd2, 32'h0000_0B73);
    wait_done("T6b", 300);
    check("T6b_issues", 32'(issue_cnt - i0), 32'd2);
    check("T6b_pops", 32'(pop_cnt - p0), 32'd2);
    check("T6b_addr1", seen_addr[1], 32'h0000_0604);
    check("T6b_dones", 32'(done_cnt - d0), 32'd1);
    check("T6b_model_empty", 32'(exp_addr.size() + exp_data.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
